// File: rtl/core_seq_pkg.sv
// +----------------------------------------------------------------------+
// | core_seq_pkg : shared types and constants for core_sequencer          |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

package core_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3,
        ST_HALT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        HC_NONE    = 2'd0,
        HC_EBREAK  = 2'd1,
        HC_REQUEST = 2'd2,
        HC_STEP    = 2'd3
    } halt_cause_t;

    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

endpackage

`default_nettype wire

// File: rtl/core_sequencer_if.sv
// +----------------------------------------------------------------------+
// | core_sequencer_if : program-load stream and imem write port          |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface core_sequencer_if #(
    parameter int XLEN = 32,
    parameter int AW   = 8
);
    logic            load_valid;
    logic [XLEN-1:0] load_data;
    logic            load_last;
    logic            load_ready;
    logic            imem_we;
    logic [AW-1:0]   imem_waddr;
    logic [XLEN-1:0] imem_wdata;

    modport master (
        output load_valid, load_data, load_last,
        input  load_ready, imem_we, imem_waddr, imem_wdata
    );

    modport slave (
        input  load_valid, load_data, load_last,
        output load_ready, imem_we, imem_waddr, imem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/sat_counter.sv
// +----------------------------------------------------------------------+
// | sat_counter : up-counter that sticks at all-ones; clr wins over inc   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             inc,
    input  wire logic             clr,
    output logic [WIDTH-1:0]      count
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;
endmodule

`default_nettype wire

// File: rtl/core_sequencer.sv
// +----------------------------------------------------------------------+
// | core_sequencer : program loader and run/halt/step control for core   |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
`default_nettype none

module core_sequencer
    import core_seq_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int XLEN       = 32
) (
    input  wire logic            clk,
    input  wire logic            rst,
    core_sequencer_if.slave      bus,
    input  wire logic            start,
    input  wire logic            halt_req,
    input  wire logic            step_req,
    input  wire logic            clear,
    input  wire logic [XLEN-1:0] instr,
    output logic                 core_en,
    output logic                 core_rst_n,
    output logic [2:0]           state,
    output logic [1:0]           halt_cause,
    output logic                 loaded,
    output logic                 load_err,
    output logic [31:0]          cycle_cnt
);
    localparam int AW = $clog2(IMEM_DEPTH);

    state_t          r_state, w_state_nxt;
    halt_cause_t     r_halt_cause, w_cause_nxt;
    logic            r_loaded, w_loaded_nxt;
    logic            r_load_err, w_err_nxt;
    logic [AW-1:0]   r_wptr, w_wptr_nxt;
    logic            r_we, w_we_nxt;
    logic [AW-1:0]   r_waddr, w_waddr_nxt;
    logic [XLEN-1:0] r_wdata, w_wdata_nxt;
    logic            r_core_rst_n, w_core_rst_n_nxt;
    logic            w_cnt_clr;
    logic            w_is_ebreak;
    logic            w_load_ready;
    logic            w_load_fire;

    assign w_is_ebreak  = (instr == XLEN'(EBREAK_INSN));
    assign w_load_ready = (r_state == ST_IDLE) || (r_state == ST_LOAD);
    assign w_load_fire  = bus.load_valid && w_load_ready;

    // An EBREAK never advances the core, so the PC stays parked on it.
    assign core_en = ((r_state == ST_RUN) || (r_state == ST_STEP)) && !w_is_ebreak;

    always_comb begin
        w_state_nxt  = r_state;
        w_cause_nxt  = r_halt_cause;
        w_loaded_nxt = r_loaded;
        w_err_nxt    = r_load_err;
        w_wptr_nxt   = r_wptr;
        w_we_nxt     = 1'b0;
        w_waddr_nxt  = r_waddr;
        w_wdata_nxt  = r_wdata;
        w_cnt_clr    = 1'b0;

        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A new word takes precedence over start: load_ready already accepted it.
                    if (w_load_fire) begin
                        w_we_nxt     = 1'b1;
                        w_waddr_nxt  = '0;
                        w_wdata_nxt  = bus.load_data;
                        w_wptr_nxt   = AW'(1);
                        w_err_nxt    = 1'b0;
                        w_loaded_nxt = bus.load_last;
                        w_state_nxt  = bus.load_last ? ST_IDLE : ST_LOAD;
                    end else if (start && r_loaded) begin
                        w_cnt_clr   = 1'b1;
                        w_cause_nxt = HC_NONE;
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_LOAD: begin
                    if (w_load_fire) begin
                        w_we_nxt    = 1'b1;
                        w_waddr_nxt = r_wptr;
                        w_wdata_nxt = bus.load_data;
                        w_wptr_nxt  = r_wptr + AW'(1);
                        if (bus.load_last) begin
                            w_loaded_nxt = 1'b1;
                            w_state_nxt  = ST_IDLE;
                        end else if (r_wptr == AW'(IMEM_DEPTH - 1)) begin
                            w_err_nxt    = 1'b1;
                            w_loaded_nxt = 1'b0;
                            w_state_nxt  = ST_IDLE;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_is_ebreak) begin
                        w_cause_nxt = HC_EBREAK;
                        w_state_nxt = ST_HALT;
                    end else if (halt_req) begin
                        w_cause_nxt = HC_REQUEST;
                        w_state_nxt = ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (halt_req) begin
                        w_state_nxt = ST_HALT;
                    end else if (start) begin
                        w_cause_nxt = HC_NONE;
                        w_state_nxt = ST_RUN;
                    end else if (step_req) begin
                        w_state_nxt = ST_STEP;
                    end
                end
                ST_STEP: begin
                    w_cause_nxt = w_is_ebreak ? HC_EBREAK : HC_STEP;
                    w_state_nxt = ST_HALT;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        w_core_rst_n_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_STEP) ||
                           (w_state_nxt == ST_HALT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_halt_cause <= HC_NONE;
            r_loaded     <= 1'b0;
            r_load_err   <= 1'b0;
            r_wptr       <= '0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_core_rst_n <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_halt_cause <= w_cause_nxt;
            r_loaded     <= w_loaded_nxt;
            r_load_err   <= w_err_nxt;
            r_wptr       <= w_wptr_nxt;
            r_we         <= w_we_nxt;
            r_waddr      <= w_waddr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_core_rst_n <= w_core_rst_n_nxt;
        end
    end

    sat_counter #(
        .WIDTH (32)
    ) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (core_en),
        .clr   (w_cnt_clr),
        .count (cycle_cnt)
    );

    assign bus.load_ready = w_load_ready;
    assign bus.imem_we    = r_we;
    assign bus.imem_waddr = r_waddr;
    assign bus.imem_wdata = r_wdata;
    assign core_rst_n     = r_core_rst_n;
    assign state          = r_state;
    assign halt_cause     = r_halt_cause;
    assign loaded         = r_loaded;
    assign load_err       = r_load_err;
endmodule

`default_nettype wire
